// File: rtl/ysyx_040066_clint.sv
// Core-local interruptor: MMIO mtime/mtimecmp timer and the machine-timer interrupt
// request/clear handshake toward the CSR file.
module ysyx_040066_clint #(
  parameter logic [63:0] BASE     = 64'h0200_0000,
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wmask,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  input  logic [63:0] mie,
  input  logic [63:0] mstatus,
  output logic        intr_req,
  output logic [63:0] intr_no,
  output logic [63:0] intr_tval,
  input  logic        intr_ack,
  output logic        clear_mip,
  output logic        mtip
);

  localparam int unsigned DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic {B_IDLE, B_RESP} bus_state_e;
  typedef enum logic [1:0] {I_IDLE, I_REQ, I_WAIT} irq_state_e;

  bus_state_e  bus_q;
  irq_state_e  irq_q;

  logic [DW-1:0] div_q, div_d;
  logic [63:0]   mtime_q, mtime_d;
  logic [63:0]   mtimecmp_q, mtimecmp_d;
  logic          mtip_q;
  logic          req_ready_q, resp_valid_q, resp_err_q;
  logic [63:0]   resp_rdata_q;
  logic          intr_req_q, clear_mip_q;

  logic          tick, accept, sel_time, sel_cmp, irq_en;
  logic [63:0]   bmask, rd_sel;

  logic unused_csr_bits;
  assign unused_csr_bits = ^{mie[63:8], mie[6:0], mstatus[63:4], mstatus[2:0]};

  always_comb begin
    tick     = (div_q == DW'(TICK_DIV - 1));
    div_d    = tick ? '0 : div_q + DW'(1);
    accept   = req_valid && req_ready_q;
    sel_time = (req_addr == BASE + 64'hBFF8);
    sel_cmp  = (req_addr == BASE + 64'h4000);
    irq_en   = mie[7] && mstatus[3];

    bmask = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      bmask[i*8 +: 8] = {8{req_wmask[i]}};
    end

    // A write to mtime replaces the tick: unmasked bytes keep the pre-tick value.
    mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
    if (accept && req_wen && sel_time) begin
      mtime_d = (mtime_q & ~bmask) | (req_wdata & bmask);
    end

    mtimecmp_d = mtimecmp_q;
    if (accept && req_wen && sel_cmp) begin
      mtimecmp_d = (mtimecmp_q & ~bmask) | (req_wdata & bmask);
    end

    rd_sel = '0;
    if (!req_wen && sel_time) rd_sel = mtime_q;
    if (!req_wen && sel_cmp)  rd_sel = mtimecmp_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q      <= '0;
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      mtip_q     <= 1'b0;
    end else begin
      div_q      <= div_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      mtip_q     <= (mtime_d >= mtimecmp_d);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_q        <= B_IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      case (bus_q)
        B_IDLE: begin
          if (accept) begin
            bus_q        <= B_RESP;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= rd_sel;
            resp_err_q   <= !(sel_time || sel_cmp);
          end
        end
        B_RESP: begin
          if (resp_ready) begin
            bus_q        <= B_IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
          end
        end
        default: bus_q <= B_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q       <= I_IDLE;
      intr_req_q  <= 1'b0;
      clear_mip_q <= 1'b0;
    end else begin
      clear_mip_q <= 1'b0;
      case (irq_q)
        I_IDLE: begin
          if (mtip_q && irq_en) begin
            irq_q      <= I_REQ;
            intr_req_q <= 1'b1;
          end
        end
        I_REQ: begin
          // Ack wins over a same-cycle enable/mtip drop: the core has already trapped.
          if (intr_ack) begin
            irq_q      <= I_WAIT;
            intr_req_q <= 1'b0;
          end else if (!(mtip_q && irq_en)) begin
            irq_q      <= I_IDLE;
            intr_req_q <= 1'b0;
          end
        end
        I_WAIT: begin
          if (!mtip_q) begin
            irq_q       <= I_IDLE;
            clear_mip_q <= 1'b1;
          end
        end
        default: begin
          irq_q      <= I_IDLE;
          intr_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign intr_req   = intr_req_q;
  assign intr_no    = 64'h8000_0000_0000_0007;
  assign intr_tval  = '0;
  assign clear_mip  = clear_mip_q;
  assign mtip       = mtip_q;

endmodule

// File: tb/tb_ysyx_040066_clint.sv
// Self-checking bench for ysyx_040066_clint: directed scenarios plus randomized MMIO
// traffic against an arithmetic model of mtime (base value + elapsed cycles).
module tb_ysyx_040066_clint;

  localparam logic [63:0] BASE = 64'h0200_0000;
  localparam logic [63:0] A_T  = BASE + 64'hBFF8;
  localparam logic [63:0] A_C  = BASE + 64'h4000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_wen = 1'b0;
  logic [63:0] req_addr = '0, req_wdata = '0;
  logic [7:0]  req_wmask = '0;
  logic        resp_valid, resp_ready = 1'b0, resp_err;
  logic [63:0] resp_rdata;
  logic [63:0] mie = '0, mstatus = '0;
  logic        intr_req, intr_ack = 1'b0, clear_mip, mtip;
  logic [63:0] intr_no, intr_tval;

  ysyx_040066_clint #(.BASE(BASE), .TICK_DIV(1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mie(mie), .mstatus(mstatus),
    .intr_req(intr_req), .intr_no(intr_no), .intr_tval(intr_tval),
    .intr_ack(intr_ack), .clear_mip(clear_mip), .mtip(mtip)
  );

  int unsigned total = 0, bad = 0;

  // Cycle index: 0 after the last reset edge, +1 per clock edge afterwards.
  logic [63:0] cyc = '0;
  always @(posedge clk) if (rst) cyc <= '0; else cyc <= cyc + 64'd1;

  // Model: mtime after edge n = m_base + (n - m_cyc0), modulo 2^64.
  logic [63:0] m_base, m_cyc0, m_cmp;

  function automatic logic [63:0] mt(input logic [63:0] n);
    return m_base + (n - m_cyc0);
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                        input logic [7:0] m);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++) if (m[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  int unsigned clr_cnt = 0, clr_pairs = 0, req_hi = 0;
  logic clr_prev = 1'b0;
  always @(negedge clk) begin
    if (clear_mip) clr_cnt++;
    if (clear_mip && clr_prev) clr_pairs++;
    clr_prev = clear_mip;
    if (intr_req) req_hi++;
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b0; intr_ack = 1'b0;
    step(2);
    rst = 1'b0;
    m_base = '0; m_cyc0 = '0; m_cmp = '1;
  endtask

  // Drives one transaction, updates the model, returns observed and expected results.
  task automatic bus(input logic wen, input logic [63:0] addr, input logic [63:0] wd,
                     input logic [7:0] wm, input int dly,
                     output logic [63:0] rd, output logic er,
                     output logic [63:0] ex_rd, output logic ex_er, output logic ok);
    int w;
    logic [63:0] n, old;
    ok = 1'b1; w = 0; rd = '0; er = 1'b0; ex_rd = '0; ex_er = 1'b0;
    while (!req_ready && w < 20) begin step(1); w++; end
    if (!req_ready) begin ok = 1'b0; return; end
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wd; req_wmask = wm;
    step(1);
    req_valid = 1'b0;
    n = cyc;
    old = mt(n - 64'd1);
    ex_er = !(addr == A_T || addr == A_C);
    ex_rd = (wen || ex_er) ? 64'd0 : (addr == A_T) ? old : m_cmp;
    if (wen && addr == A_T) begin m_base = merge(old, wd, wm); m_cyc0 = n; end
    if (wen && addr == A_C) m_cmp = merge(m_cmp, wd, wm);
    if (!(resp_valid === 1'b1 && req_ready === 1'b0)) ok = 1'b0;
    rd = resp_rdata; er = resp_err;
    for (int i = 0; i < dly; i++) begin
      step(1);
      if (!(resp_valid === 1'b1 && req_ready === 1'b0 && resp_rdata === rd && resp_err === er))
        ok = 1'b0;
    end
    resp_ready = 1'b1;
    step(1);
    resp_ready = 1'b0;
    if (!(resp_valid === 1'b0 && req_ready === 1'b1)) ok = 1'b0;
  endtask

  logic [63:0] rd, exr;
  logic er, exe, ok;

  task automatic test_reset();
    do_reset();
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    total++; if (resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 64'd0) begin
      bad++; $display("FAIL reset_resp: got v=%b e=%b d=%h want 0/0/0", resp_valid, resp_err, resp_rdata); end
    total++; if (intr_req !== 1'b0 || clear_mip !== 1'b0 || mtip !== 1'b0) begin
      bad++; $display("FAIL reset_irq: got req=%b clr=%b mtip=%b want 0/0/0", intr_req, clear_mip, mtip); end
    step(3);
    bus(1'b0, A_T, '0, '0, 0, rd, er, exr, exe, ok);
    total++; if (rd !== 64'd3 || er !== 1'b0 || ok !== 1'b1) begin
      bad++; $display("FAIL reset_mtime3: got %h err=%b hs=%b want 3 0 1", rd, er, ok); end
    bus(1'b0, A_C, '0, '0, 1, rd, er, exr, exe, ok);
    total++; if (rd !== 64'hFFFF_FFFF_FFFF_FFFF || ok !== 1'b1) begin
      bad++; $display("FAIL reset_mtimecmp: got %h hs=%b want all-ones 1", rd, ok); end
    // Reset asserted while a response is pending drops it.
    req_valid = 1'b1; req_wen = 1'b0; req_addr = A_T;
    step(1);
    req_valid = 1'b0;
    do_reset();
    total++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL reset_midtxn: got v=%b rdy=%b want 0 1", resp_valid, req_ready); end
  endtask

  task automatic test_timer_irq();
    int w;
    logic held;
    do_reset();
    mie = 64'h80; mstatus = 64'h8;
    bus(1'b1, A_C, 64'd10, 8'hFF, 0, rd, er, exr, exe, ok);
    w = 0;
    while (!mtip && w < 50) begin step(1); w++; end
    total++; if (mtip !== 1'b1 || mt(cyc) !== 64'd10) begin
      bad++; $display("FAIL mtip_rise: got mtip=%b mtime=%0d want 1 at 10", mtip, mt(cyc)); end
    total++; if (intr_req !== 1'b0) begin bad++; $display("FAIL irq_early: got %b want 0", intr_req); end
    step(1);
    total++; if (intr_req !== 1'b1 || intr_no !== 64'h8000_0000_0000_0007 || intr_tval !== 64'd0) begin
      bad++; $display("FAIL irq_raise: got req=%b no=%h tval=%h want 1 8000000000000007 0", intr_req, intr_no, intr_tval); end
    held = 1'b1;
    for (int i = 0; i < int'($urandom_range(2, 6)); i++) begin step(1); if (intr_req !== 1'b1) held = 1'b0; end
    total++; if (held !== 1'b1) begin bad++; $display("FAIL irq_hold: got %b want 1", held); end
    intr_ack = 1'b1; step(1); intr_ack = 1'b0;
    total++; if (intr_req !== 1'b0) begin bad++; $display("FAIL irq_ack: got %b want 0", intr_req); end
  endtask

  task automatic test_clear_mip();
    int unsigned c0, p0, r0;
    int w;
    c0 = clr_cnt; p0 = clr_pairs; r0 = req_hi;
    step(3);
    total++; if (clr_cnt != c0 || req_hi != r0) begin
      bad++; $display("FAIL wait_quiet: got clr=%0d req=%0d want %0d %0d", clr_cnt, req_hi, c0, r0); end
    bus(1'b1, A_C, mt(cyc + 64'd1) + 64'd100, 8'hFF, 0, rd, er, exr, exe, ok);
    step(8);
    total++; if (clr_cnt - c0 != 1 || clr_pairs != p0 || mtip !== 1'b0) begin
      bad++; $display("FAIL clear_pulse: got pulses=%0d long=%0d mtip=%b want 1 0 0", clr_cnt - c0, clr_pairs - p0, mtip); end
    w = 0;
    while (!mtip && w < 200) begin step(1); w++; end
    total++; if (mtip !== 1'b1 || mt(cyc) !== m_cmp || req_hi != r0) begin
      bad++; $display("FAIL recompare: got mtip=%b mtime=%h req_cycles=%0d want 1 %h %0d", mtip, mt(cyc), req_hi - r0, m_cmp, 0); end
    step(1);
    total++; if (intr_req !== 1'b1) begin bad++; $display("FAIL rearm: got %b want 1", intr_req); end
    intr_ack = 1'b1; step(1); intr_ack = 1'b0;
  endtask

  task automatic test_enable_gate();
    int unsigned r0, c0;
    do_reset();
    mie = 64'h80; mstatus = 64'h0;
    bus(1'b1, A_C, 64'd0, 8'hFF, 0, rd, er, exr, exe, ok);
    r0 = req_hi;
    step(5);
    total++; if (mtip !== 1'b1 || intr_req !== 1'b0 || req_hi != r0) begin
      bad++; $display("FAIL gate_off: got mtip=%b req=%b want 1 0", mtip, intr_req); end
    mstatus = 64'h8;
    step(1);
    total++; if (intr_req !== 1'b1) begin bad++; $display("FAIL gate_on: got %b want 1", intr_req); end
    c0 = clr_cnt;
    mstatus = 64'h0;
    step(2);
    total++; if (intr_req !== 1'b0 || clr_cnt != c0) begin
      bad++; $display("FAIL gate_drop: got req=%b clr=%0d want 0 0", intr_req, clr_cnt - c0); end
  endtask

  task automatic test_masked_write();
    do_reset();
    mie = '0; mstatus = '0;
    bus(1'b1, A_T, 64'h0000_0001_FFFF_FFF0, 8'hFF, 0, rd, er, exr, exe, ok);
    bus(1'b1, A_T, 64'h1234_5678_DEAD_BEEF, 8'h0F, 0, rd, er, exr, exe, ok);
    total++; if (mt(m_cyc0) !== 64'h0000_0001_DEAD_BEEF) begin
      bad++; $display("FAIL mask_model: got %h want 00000001deadbeef", mt(m_cyc0)); end
    bus(1'b0, A_T, '0, '0, 0, rd, er, exr, exe, ok);
    total++; if (rd !== exr || rd[63:32] !== 32'h1 || ok !== 1'b1) begin
      bad++; $display("FAIL mask_write: got %h want %h", rd, exr); end
    bus(1'b1, A_T, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, 0, rd, er, exr, exe, ok);
    step(2);
    bus(1'b0, A_T, '0, '0, 0, rd, er, exr, exe, ok);
    total++; if (rd !== exr || rd > 64'd10) begin
      bad++; $display("FAIL mtime_wrap: got %h want %h", rd, exr); end
  endtask

  task automatic test_error();
    logic [63:0] t0;
    bus(1'b0, BASE + 64'h10, '0, '0, 5, rd, er, exr, exe, ok);
    total++; if (er !== 1'b1 || rd !== 64'd0 || ok !== 1'b1) begin
      bad++; $display("FAIL err_read: got err=%b d=%h hs=%b want 1 0 1", er, rd, ok); end
    t0 = m_cmp;
    bus(1'b1, BASE + 64'h4008, 64'h5555, 8'hFF, 2, rd, er, exr, exe, ok);
    bus(1'b1, BASE + 64'h4004, 64'h6666, 8'hFF, 0, rd, er, exr, exe, ok);
    total++; if (er !== 1'b1) begin bad++; $display("FAIL err_write: got %b want 1", er); end
    bus(1'b0, A_C, '0, '0, 0, rd, er, exr, exe, ok);
    total++; if (rd !== t0 || er !== 1'b0) begin
      bad++; $display("FAIL err_nowrite: got %h want %h", rd, t0); end
  endtask

  task automatic test_random();
    int op, dly;
    logic [63:0] a, d;
    int unsigned r0;
    do_reset();
    mie = '0; mstatus = 64'h8;
    r0 = req_hi;
    for (int k = 0; k < 60; k++) begin
      op = int'($urandom_range(0, 5));
      dly = int'($urandom_range(0, 3));
      d = {$urandom, $urandom};
      case (op)
        0: bus(1'b0, A_T, '0, '0, dly, rd, er, exr, exe, ok);
        1: bus(1'b0, A_C, '0, '0, dly, rd, er, exr, exe, ok);
        2: bus(1'b1, A_T, d, 8'($urandom), dly, rd, er, exr, exe, ok);
        3: begin
          if ($urandom_range(0, 1) == 1) d = mt(cyc) + 64'($urandom_range(0, 8));
          bus(1'b1, A_C, d, 8'($urandom), dly, rd, er, exr, exe, ok);
        end
        4: begin
          a = BASE + {48'd0, 16'($urandom) & 16'hFFF8};
          if ($urandom_range(0, 3) == 0) a = {$urandom, $urandom};
          if (a == A_T || a == A_C) a = a ^ 64'h1;
          bus(1'($urandom), a, d, 8'hFF, dly, rd, er, exr, exe, ok);
        end
        default: begin step(int'($urandom_range(1, 4))); ok = 1'b1; rd = '0; er = 1'b0; exr = '0; exe = 1'b0; end
      endcase
      total++; if (rd !== exr || er !== exe || ok !== 1'b1) begin
        bad++; $display("FAIL rand_op%0d: got d=%h e=%b hs=%b want d=%h e=%b", op, rd, er, ok, exr, exe); end
      total++; if (mtip !== (mt(cyc) >= m_cmp)) begin
        bad++; $display("FAIL rand_mtip%0d: got %b want %b", k, mtip, mt(cyc) >= m_cmp); end
    end
    total++; if (req_hi != r0) begin bad++; $display("FAIL rand_noirq: got %0d want 0", req_hi - r0); end
  endtask

  initial begin
    test_reset();
    test_timer_irq();
    test_clear_mip();
    test_enable_gate();
    test_masked_write();
    test_error();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
